// File: rtl/bcd_display_scanner.sv
// Two-digit seven-segment scanner: captures a packed BCD word via valid/ready and
// time-multiplexes ones/tens onto a shared segment bus. Optional: LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       bcd_valid,
  output logic       bcd_ready,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       err
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN_ONES = 2'd1,
    SCAN_TENS = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       disp;
  logic             xfer;
  logic             bad_word;
  logic             cnt_last;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign cnt_last = (cnt == CNT_LAST);
  assign xfer     = bcd_valid && bcd_ready;
  assign bad_word = (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      disp  <= 8'h00;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (xfer) begin
        disp <= bcd_in;
        if (bad_word) err <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bcd_ready  = 1'b0;
    seg        = 7'h00;
    digit_en   = 2'b00;
    case (state)
      IDLE: begin
        bcd_ready = 1'b1;
        if (bcd_valid) begin
          state_next = SCAN_ONES;
          cnt_next   = '0;
        end
      end
      SCAN_ONES: begin
        digit_en = 2'b01;
        seg      = decode(disp[3:0]);
        if (cnt_last) begin
          cnt_next   = '0;
          state_next = SCAN_TENS;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SCAN_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        // A zero tens digit keeps its slot but drives nothing.
        if (disp[7:4] != 4'd0) begin
          digit_en = 2'b10;
          seg      = decode(disp[7:4]);
        end
`else
        digit_en = 2'b10;
        seg      = decode(disp[7:4]);
`endif
        // Accepting only in the last tens cycle keeps each frame coherent.
        bcd_ready = cnt_last;
        if (cnt_last) begin
          cnt_next   = '0;
          state_next = SCAN_ONES;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Two-digit seven-segment display scanner that sits directly downstream of the 4-bit binary-to-BCD converter. It captures the converter's packed 8-bit BCD word ({tens, ones}) through a valid/ready handshake and time-multiplexes the two digits onto a shared segment bus. Each digit is held for a programmable number of clock cycles.

## Interface
- REFRESH_DIV, 4, clock cycles each digit is driven per scan slot; legal range 2..65535.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- bcd_in  input  8  packed BCD: [7:4] tens, [3:0] ones.
- bcd_valid  input  1  bcd_in is valid this cycle.
- bcd_ready  output  1  scanner will capture bcd_in this cycle if bcd_valid is high.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- digit_en  output  2  one-hot digit select, active-high: [0] ones, [1] tens.
- err  output  1  sticky flag: a captured nibble was greater than 9.

## Operation
- **Storage:** 8-bit register `disp`, prescale counter `cnt` with width ceil(log2(REFRESH_DIV)), sticky `err`.
- **FSM states:** IDLE, SCAN_ONES, SCAN_TENS.
- **Transfer:** a transfer occurs on any cycle where bcd_valid && bcd_ready. On transfer, `disp` <= bcd_in at the next edge.
- **bcd_ready:**
  - 1 in IDLE.
  - 1 in SCAN_TENS when cnt == REFRESH_DIV-1.
  - 0 otherwise.
  - Decoded from registered state only; never depends on bcd_valid.
- **IDLE:** entered after reset. seg = 0, digit_en = 00. On transfer, go to SCAN_ONES with cnt = 0.
- **SCAN_ONES:** digit_en = 01, seg = decode(disp[3:0]). cnt increments each cycle. At REFRESH_DIV-1, cnt wraps to 0 and the FSM goes to SCAN_TENS.
- **SCAN_TENS:** digit_en = 10, seg = decode(disp[7:4]). cnt increments each cycle. At REFRESH_DIV-1, cnt wraps to 0 and the FSM goes to SCAN_ONES; `disp` loads bcd_in if a transfer occurs, otherwise it keeps its value.
- **Scanning:** once any word has been captured, scanning never returns to IDLE except through reset.
- **Decode values:** 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- **Invalid nibbles:** values 10..15 decode to 0x00 (blank).
- **err:** set at the edge that captures a word where either nibble is greater than 9. Cleared only by rst.

## Timing
- **Reset values:** state = IDLE, cnt = 0, disp = 0x00, err = 0, seg = 0x00, digit_en = 00, bcd_ready = 1.
- **Reset priority:** rst has priority over a same-cycle transfer; that word is dropped.
- **No combinational input paths:** seg and digit_en are decoded from registered state and `disp` only; there is no path from bcd_in.
- **Load latency:** a transfer at edge N shows its ones digit from the cycle after edge N.
- **Frame period:** 2×REFRESH_DIV cycles; each digit slot lasts exactly REFRESH_DIV cycles.
- **Update timing:** new data is accepted only at a frame boundary, so a displayed frame never mixes old and new digits.
- **Ready rate while scanning:** bcd_ready is high for exactly one cycle per frame.
- **Held valid:** a producer holding bcd_valid high sees exactly one transfer per frame. bcd_in must stay stable while bcd_valid is high and bcd_ready is low.
- **Counter boundary:** the cnt wrap and the state change happen on the same edge; no cycle has digit_en = 00 between slots, except the blanking case defined under Configuration.

## Configuration
- **Macro:** LEADING_ZERO_BLANK_EN.
- **Defined:** in SCAN_TENS, when disp[7:4] == 0, seg = 0x00 and digit_en = 00. Slot timing is unchanged, as are bcd_ready and cnt.
- **Undefined:** a zero tens digit displays as 0x3F with digit_en = 10.

## Test plan
- **Reset then idle:** assert rst for 2 cycles, then hold bcd_valid = 0 for 20 cycles -> seg = 0x00, digit_en = 00, bcd_ready = 1, err = 0 throughout.
- **Basic scan:** REFRESH_DIV = 4; transfer bcd_in = 0x15 from IDLE -> from the next cycle, 4 cycles of digit_en = 01 / seg = 0x6D, then 4 cycles of digit_en = 10 / seg = 0x06, repeating with period 8.
- **Frame-boundary handshake:** with 0x15 scanning, raise bcd_valid with 0x07 in the 2nd ones cycle -> bcd_ready stays 0 until the 4th tens cycle. The transfer happens there, and the next ones slot shows 0x07, then a tens slot of 0x3F (macro undefined).
- **Invalid digit:** transfer 0x0A -> err = 1 and the ones slot has seg = 0x00. Then transfer 0x09 -> the ones slot shows 0x6F and err remains 1.
- **Leading-zero blanking:** transfer 0x03 -> with LEADING_ZERO_BLANK_EN, the tens slot has digit_en = 00 and seg = 0x00; without it, digit_en = 10 and seg = 0x3F. The ones slot shows 0x4F in both builds.
- **Reset mid-operation:** assert rst in the last SCAN_TENS cycle with bcd_valid = 1 and bcd_in = 0x12 -> next cycle state is IDLE, seg = 0x00, digit_en = 00, err = 0, and 0x12 is not captured.
